// File: rtl/mmio_requester_pkg.sv
// Shared types for the MMIO requester: FSM state encoding and the latched request record.
package mmio_requester_pkg;

    localparam int unsigned MMIO_TAG_LEN = 6;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdData,
        StWrReq,
        StResp
    } MMIOReqState_t;

    typedef struct packed {
        logic                    we;
        logic [31:0]             addr;
        logic [31:0]             wdata;
        logic [3:0]              wmask;
        logic [MMIO_TAG_LEN-1:0] tag;
    } MMIOReq_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mmio_requester.sv
// Single-outstanding MMIO requester bridging a core request/response port to strobe-based buses.
// Optional bus-busy timeout is enabled by defining MMIO_TIMEOUT_EN.
module mmio_requester
    import mmio_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    IN_reqValid,
    output logic                    OUT_reqReady,
    input  logic                    IN_reqWe,
    input  logic [31:0]             IN_reqAddr,
    input  logic [31:0]             IN_reqWData,
    input  logic [3:0]              IN_reqWMask,
    input  logic [MMIO_TAG_LEN-1:0] IN_reqTag,

    output logic                    OUT_respValid,
    input  logic                    IN_respReady,
    output logic [31:0]             OUT_respData,
    output logic [MMIO_TAG_LEN-1:0] OUT_respTag,
    output logic                    OUT_respErr,

    output logic                    OUT_re,
    output logic [31:0]             OUT_raddr,
    input  logic                    IN_rbusy,
    input  logic [31:0]             IN_rdata,

    output logic                    OUT_we,
    output logic [31:0]             OUT_waddr,
    output logic [31:0]             OUT_wdata,
    output logic [3:0]              OUT_wmask,
    input  logic                    IN_wbusy
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mmio_requester: TIMEOUT must be nonzero");
    end

    MMIOReqState_t state_q;
    MMIOReq_t      req_q;
    logic          re_q;
    logic          we_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_data_q;

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CntW-1:0] TimeoutMax = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            timed_out;

    assign cnt_d     = cnt_q + 1'b1;
    assign timed_out = cnt_d >= TimeoutMax;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= '0;
            re_q         <= 1'b1;
            we_q         <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (IN_reqValid) begin
                        req_q.we    <= IN_reqWe;
                        req_q.addr  <= IN_reqAddr;
                        req_q.wdata <= IN_reqWData;
                        req_q.wmask <= IN_reqWMask;
                        req_q.tag   <= IN_reqTag;
`ifdef MMIO_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                        if (is_misaligned(IN_reqAddr)) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else if (IN_reqWe) begin
                            state_q <= StWrReq;
                            we_q    <= 1'b0;
                        end else begin
                            state_q <= StRdReq;
                            re_q    <= 1'b0;
                        end
                    end
                end
                StRdReq: begin
                    if (!IN_rbusy) begin
                        state_q <= StRdData;
                        re_q    <= 1'b1;
`ifdef MMIO_TIMEOUT_EN
                    end else if (timed_out) begin
                        state_q      <= StResp;
                        re_q         <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_d;
`endif
                    end
                end
                StRdData: begin
                    // Responder drives read data one cycle after the strobe is accepted.
                    state_q      <= StResp;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= req_q.we ? '0 : IN_rdata;
                end
                StWrReq: begin
                    if (!IN_wbusy) begin
                        state_q      <= StResp;
                        we_q         <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= '0;
`ifdef MMIO_TIMEOUT_EN
                    end else if (timed_out) begin
                        state_q      <= StResp;
                        we_q         <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_d;
`endif
                    end
                end
                StResp: begin
                    if (IN_respReady) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    re_q    <= 1'b1;
                    we_q    <= 1'b1;
                end
            endcase
        end
    end

    assign OUT_reqReady  = (state_q == StIdle);
    assign OUT_respValid = resp_valid_q;
    assign OUT_respData  = resp_data_q;
    assign OUT_respTag   = req_q.tag;
    assign OUT_respErr   = resp_err_q;

    assign OUT_re    = re_q;
    assign OUT_raddr = req_q.addr;
    assign OUT_we    = we_q;
    assign OUT_waddr = req_q.addr;
    assign OUT_wdata = req_q.wdata;
    assign OUT_wmask = req_q.wmask;

endmodule

// File: tb/tb_mmio_requester.sv
// Self-checking bench for mmio_requester: directed scenarios plus randomized transactions
// checked against a cycle-count/response model. Honours MMIO_TIMEOUT_EN when defined.
module tb_mmio_requester;

    localparam int TimeoutP = 4;
`ifdef MMIO_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_reqValid, OUT_reqReady, IN_reqWe;
    logic [31:0] IN_reqAddr, IN_reqWData;
    logic [3:0]  IN_reqWMask;
    logic [5:0]  IN_reqTag;
    logic        OUT_respValid, IN_respReady;
    logic [31:0] OUT_respData;
    logic [5:0]  OUT_respTag;
    logic        OUT_respErr;
    logic        OUT_re, IN_rbusy;
    logic [31:0] OUT_raddr, IN_rdata;
    logic        OUT_we, IN_wbusy;
    logic [31:0] OUT_waddr, OUT_wdata;
    logic [3:0]  OUT_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_requester #(.TIMEOUT(TimeoutP)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_reqValid  (IN_reqValid),
        .OUT_reqReady (OUT_reqReady),
        .IN_reqWe     (IN_reqWe),
        .IN_reqAddr   (IN_reqAddr),
        .IN_reqWData  (IN_reqWData),
        .IN_reqWMask  (IN_reqWMask),
        .IN_reqTag    (IN_reqTag),
        .OUT_respValid(OUT_respValid),
        .IN_respReady (IN_respReady),
        .OUT_respData (OUT_respData),
        .OUT_respTag  (OUT_respTag),
        .OUT_respErr  (OUT_respErr),
        .OUT_re       (OUT_re),
        .OUT_raddr    (OUT_raddr),
        .IN_rbusy     (IN_rbusy),
        .IN_rdata     (IN_rdata),
        .OUT_we       (OUT_we),
        .OUT_waddr    (OUT_waddr),
        .OUT_wdata    (OUT_wdata),
        .OUT_wmask    (OUT_wmask),
        .IN_wbusy     (IN_wbusy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. busy = number of strobe-low cycles the responder reports busy,
    // rdly = cycles respReady is withheld once the response appears, spam = keep reqValid high.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [5:0] tag, input int busy,
                          input int rdly, input logic [31:0] rdata, input bit spam);
        int          exp_low, exp_resp, cyc, low, resp_cyc, waited;
        bit          exp_err, rd_accepted, done;
        logic [31:0] exp_data;

        if (addr[1:0] != 2'b00) begin
            exp_low = 0; exp_resp = 1; exp_err = 1'b1; exp_data = 32'h0;
        end else if (TimeoutOn && busy >= TimeoutP) begin
            exp_low = TimeoutP; exp_resp = TimeoutP + 1; exp_err = 1'b1; exp_data = 32'h0;
        end else begin
            exp_low  = busy + 1;
            exp_resp = we ? busy + 2 : busy + 3;
            exp_err  = 1'b0;
            exp_data = we ? 32'h0 : rdata;
        end

        check("idle_ready", {31'b0, OUT_reqReady}, 32'd1);
        IN_reqValid = 1'b1; IN_reqWe = we; IN_reqAddr = addr; IN_reqWData = wdata;
        IN_reqWMask = wmask; IN_reqTag = tag; IN_respReady = 1'b0;
        IN_rbusy = 1'b0; IN_wbusy = 1'b0;

        cyc = 0; low = 0; resp_cyc = -1; waited = 0; rd_accepted = 1'b0; done = 1'b0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            IN_reqValid = spam;
            IN_reqWe    = 1'($urandom);
            IN_reqAddr  = $urandom;
            IN_reqWData = $urandom;
            IN_reqWMask = 4'($urandom);
            IN_reqTag   = 6'($urandom);
            IN_rdata    = rd_accepted ? rdata : $urandom;
            rd_accepted = 1'b0;
            IN_rbusy = 1'b0; IN_wbusy = 1'b0; IN_respReady = 1'b0;
            if (!OUT_re && !OUT_we) check("both_strobes_low", 32'd1, 32'd0);
            if (!OUT_re) begin
                low++;
                check("raddr_stable", OUT_raddr, addr);
                IN_rbusy = (low <= busy);
                rd_accepted = !IN_rbusy;
            end
            if (!OUT_we) begin
                low++;
                check("waddr_stable", OUT_waddr, addr);
                check("wdata_stable", OUT_wdata, wdata);
                check("wmask_stable", {28'b0, OUT_wmask}, {28'b0, wmask});
                IN_wbusy = (low <= busy);
            end
            if (OUT_respValid) begin
                if (resp_cyc < 0) begin
                    resp_cyc = cyc;
                    check("resp_cycle", resp_cyc, exp_resp);
                    check("strobe_low_cycles", low, exp_low);
                end
                check("resp_data", OUT_respData, exp_data);
                check("resp_tag", {26'b0, OUT_respTag}, {26'b0, tag});
                check("resp_err", {31'b0, OUT_respErr}, {31'b0, exp_err});
                check("busy_not_ready", {31'b0, OUT_reqReady}, 32'd0);
                if (waited >= rdly) begin
                    IN_respReady = 1'b1;
                    IN_reqValid  = 1'b0;
                    done = 1'b1;
                end
                waited++;
            end else begin
                check("busy_not_ready", {31'b0, OUT_reqReady}, 32'd0);
            end
        end
        if (!done) check("txn_completed", 32'd0, 32'd1);
        tick();
        IN_respReady = 1'b0;
        IN_reqValid  = 1'b0;
        check("resp_dropped", {31'b0, OUT_respValid}, 32'd0);
        check("back_to_idle", {31'b0, OUT_reqReady}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        IN_reqValid = 1'b0; IN_reqWe = 1'b0; IN_reqAddr = 32'h0; IN_reqWData = 32'h0;
        IN_reqWMask = 4'h0; IN_reqTag = 6'h0; IN_respReady = 1'b0;
        IN_rbusy = 1'b0; IN_rdata = 32'h0; IN_wbusy = 1'b0;
        tick();
        tick();

        check("rst_re", {31'b0, OUT_re}, 32'd1);
        check("rst_we", {31'b0, OUT_we}, 32'd1);
        check("rst_resp_valid", {31'b0, OUT_respValid}, 32'd0);
        check("rst_resp_err", {31'b0, OUT_respErr}, 32'd0);
        check("rst_resp_data", OUT_respData, 32'h0);
        check("rst_resp_tag", {26'b0, OUT_respTag}, 32'h0);
        check("rst_raddr", OUT_raddr, 32'h0);
        check("rst_waddr", OUT_waddr, 32'h0);
        check("rst_wdata", OUT_wdata, 32'h0);
        check("rst_wmask", {28'b0, OUT_wmask}, 32'h0);
        check("rst_req_ready", {31'b0, OUT_reqReady}, 32'd1);
        rst = 1'b0;
        tick();

        // Minimum-latency read, busy write, misaligned read, stalled response with spam.
        do_txn(1'b0, 32'h0200_0000, 32'h0, 4'h0, 6'h15, 0, 0, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b1, 32'h1110_0000, 32'h0000_5555, 4'hF, 6'h2A, 3, 0, 32'h0, 1'b0);
        do_txn(1'b0, 32'h0200_0003, 32'h0, 4'h0, 6'h07, 0, 0, 32'h1234_5678, 1'b0);
        do_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 6'h3C, 1, 5, 32'hCAFE_F00D, 1'b1);
        do_txn(1'b1, 32'h0000_2002, 32'hFFFF_0000, 4'h3, 6'h01, 0, 2, 32'h0, 1'b1);
        do_txn(1'b1, 32'h0000_3000, 32'hA5A5_5A5A, 4'h5, 6'h11, 0, 0, 32'h0, 1'b0);

        // Busy stuck: times out when enabled, otherwise the strobe just waits.
        do_txn(1'b0, 32'h0000_4000, 32'h0, 4'h0, 6'h22, TimeoutOn ? 100 : 30, 0,
               32'h0BAD_0BAD, 1'b0);
        do_txn(1'b1, 32'h0000_5000, 32'h1357_9BDF, 4'hC, 6'h23, TimeoutOn ? 100 : 20, 1,
               32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            do_txn(1'($urandom), a, $urandom, 4'($urandom), 6'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                   1'($urandom));
        end

        // Reset while the write strobe is low: strobe released, no response.
        IN_reqValid = 1'b1; IN_reqWe = 1'b1; IN_reqAddr = 32'h0000_6000;
        IN_reqWData = 32'h7777_8888; IN_reqWMask = 4'hF; IN_reqTag = 6'h3F;
        tick();
        IN_reqValid = 1'b0; IN_wbusy = 1'b1;
        check("pre_rst_we_low", {31'b0, OUT_we}, 32'd0);
        tick();
        check("pre_rst_we_still_low", {31'b0, OUT_we}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        IN_wbusy = 1'b0;
        IN_respReady = 1'b1;
        check("mid_rst_we_high", {31'b0, OUT_we}, 32'd1);
        check("mid_rst_idle", {31'b0, OUT_reqReady}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_no_resp", {31'b0, OUT_respValid}, 32'd0);
            tick();
        end
        IN_respReady = 1'b0;
        do_txn(1'b0, 32'h0000_7000, 32'h0, 4'h0, 6'h05, 0, 0, 32'h600D_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
